// File: rtl/ip_codma_sched.sv
// Task scheduler in front of ip_codma_top: queues (task, status) pointer
// pairs and launches them one at a time on the CoDMA start/stop/busy pins.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   push_i, push_*_ptr_i    enqueue request and payload
//   push_ready_o            queue not full
//   abort_i                 stop current task and flush queue
//   codma_start_o/stop_o    control pulses/levels to CoDMA
//   codma_busy_i            CoDMA busy
//   codma_*_ptr_o           pointers of the task in flight
//   done_o, done_count_o    completion pulse and wrapping count
//   queue_level_o, idle_o   queue fill and idle indication
//   err_o                   sticky overflow / start-timeout flag
module ip_codma_sched #(
  parameter int QUEUE_DEPTH   = 4,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [31:0]                  push_task_ptr_i,
  input  logic [31:0]                  push_status_ptr_i,
  output logic                         push_ready_o,
  input  logic                         abort_i,
  output logic                         codma_start_o,
  output logic                         codma_stop_o,
  input  logic                         codma_busy_i,
  output logic [31:0]                  codma_task_ptr_o,
  output logic [31:0]                  codma_status_ptr_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             done_count_o,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level_o,
  output logic                         idle_o,
  output logic                         err_o
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(QUEUE_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state;

  logic [31:0] task_q [QUEUE_DEPTH];
  logic [31:0] stat_q [QUEUE_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        push_ok;
  logic        pop;
  logic [TW-1:0] tmo;

  // Extra pointer bit distinguishes full from empty.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push_i && !full && !abort_i;
  assign pop     = (state == S_IDLE) && !empty && !abort_i;

  assign push_ready_o  = !full;
  assign queue_level_o = level;
  assign idle_o        = (state == S_IDLE) && empty;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      task_q[wr_ptr[AW-1:0]] <= push_task_ptr_i;
      stat_q[wr_ptr[AW-1:0]] <= push_status_ptr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort_i) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outputs are registered alongside the state, so they follow it
  // exactly one edge after the decision.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state              <= S_IDLE;
      codma_start_o      <= 1'b0;
      codma_stop_o       <= 1'b0;
      done_o             <= 1'b0;
      done_count_o       <= '0;
      codma_task_ptr_o   <= '0;
      codma_status_ptr_o <= '0;
      err_o              <= 1'b0;
      tmo                <= '0;
    end else begin
      done_o <= 1'b0;
      if (push_i && full) err_o <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            codma_task_ptr_o   <= task_q[rd_ptr[AW-1:0]];
            codma_status_ptr_o <= stat_q[rd_ptr[AW-1:0]];
            codma_start_o      <= 1'b1;
            tmo                <= '0;
            state              <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (abort_i) begin
            codma_start_o <= 1'b0;
            codma_stop_o  <= 1'b1;
            state         <= S_ABORT;
          end else if (codma_busy_i) begin
            codma_start_o <= 1'b0;
            state         <= S_RUN;
          end else if (tmo == TMO_LAST) begin
            codma_start_o <= 1'b0;
            err_o         <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            codma_stop_o <= 1'b1;
            state        <= S_ABORT;
          end else if (!codma_busy_i) begin
            done_o       <= 1'b1;
            done_count_o <= done_count_o + 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ABORT: begin
          if (!codma_busy_i) begin
            codma_stop_o <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          codma_start_o <= 1'b0;
          codma_stop_o  <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_codma_sched.sv
// Directed bench for ip_codma_sched with a behavioural CoDMA busy model
// and a launch scoreboard checked on every rising codma_start_o.
module tb_ip_codma_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [31:0] tp;
  logic [31:0] sp;
  logic        ready;
  logic        abort;
  logic        start;
  logic        stop;
  logic        busy;
  logic [31:0] task_ptr;
  logic [31:0] stat_ptr;
  logic        done;
  logic [15:0] count;
  logic [2:0]  level;
  logic        idle;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];
  logic [63:0] mon_exp;
  logic        prev_start = 1'b0;

  // 0: busy low, 1: busy 3 cycles after start for 10 cycles,
  // 2: busy sticky after start, 3: busy drops 3 edges after stop
  int mode = 0;
  int t = 0;
  int s = 0;

  always #5 clk = ~clk;

  ip_codma_sched dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .push_i             (push),
    .push_task_ptr_i    (tp),
    .push_status_ptr_i  (sp),
    .push_ready_o       (ready),
    .abort_i            (abort),
    .codma_start_o      (start),
    .codma_stop_o       (stop),
    .codma_busy_i       (busy),
    .codma_task_ptr_o   (task_ptr),
    .codma_status_ptr_o (stat_ptr),
    .done_o             (done),
    .done_count_o       (count),
    .queue_level_o      (level),
    .idle_o             (idle),
    .err_o              (err)
  );

  always @(posedge clk) begin
    if (mode == 1) begin
      if (t == 0) begin
        busy <= 1'b0;
        if (start) t <= 1;
      end else if (t < 3) begin
        t <= t + 1;
      end else if (t < 13) begin
        busy <= 1'b1;
        t <= t + 1;
      end else begin
        busy <= 1'b0;
        t <= 0;
      end
    end else if (mode == 2) begin
      if (start) busy <= 1'b1;
    end else if (mode == 3) begin
      if (start) begin
        busy <= 1'b1;
        s <= 0;
      end else if (stop) begin
        if (s >= 2) busy <= 1'b0;
        s <= s + 1;
      end
    end else begin
      busy <= 1'b0;
      t <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every launch must carry the oldest still-expected pointer pair.
  always @(negedge clk) begin
    if (start && !prev_start) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        chk("launch_ptrs", {task_ptr, stat_ptr}, mon_exp);
      end
    end
    prev_start <= start;
  end

  task automatic do_reset();
    reset = 1'b1;
    push  = 1'b0;
    abort = 1'b0;
    mode  = 0;
    sb.delete();
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int n2;
    reset = 1'b1;
    push  = 1'b0;
    abort = 1'b0;
    tp    = '0;
    sp    = '0;
    busy  = 1'b0;
    cyc(2);
    reset = 1'b0;

    // Reset state
    chk("rst_idle", idle, 1);
    chk("rst_ready", ready, 1);
    chk("rst_start", start, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_level", level, 0);

    // Single task, normal completion
    mode = 1;
    push = 1'b1;
    tp = 32'h40;
    sp = 32'h80;
    sb.push_back({32'h40, 32'h80});
    cyc(1);
    push = 1'b0;
    chk("lat_c1_start", start, 0);
    chk("lat_c1_level", level, 1);
    cyc(1);
    chk("lat_c2_start", start, 1);
    chk("task_ptr", task_ptr, 32'h40);
    chk("stat_ptr", stat_ptr, 32'h80);
    n = 0;
    repeat (40) begin
      cyc(1);
      if (done) n++;
    end
    chk("one_done", n, 1);
    chk("count_1", count, 1);
    chk("idle_after", idle, 1);
    chk("no_err", err, 0);

    // Overflow: 6 pushes, first one popped, 6th dropped
    do_reset();
    mode = 2;
    for (int i = 0; i < 6; i++) begin
      push = 1'b1;
      tp = 32'h100 + i;
      sp = 32'h200 + i;
      if (i < 5) sb.push_back({32'h100 + i, 32'h200 + i});
      if (i == 5) begin
        chk("full_ready", ready, 0);
        chk("full_err_pre", err, 0);
      end
      cyc(1);
    end
    push = 1'b0;
    chk("ovf_err", err, 1);
    chk("ovf_level", level, 4);

    // Start timeout
    do_reset();
    push = 1'b1;
    tp = 32'h300;
    sp = 32'h400;
    sb.push_back({32'h300, 32'h400});
    cyc(1);
    push = 1'b0;
    n = 0;
    repeat (40) begin
      if (start) n++;
      cyc(1);
    end
    chk("tmo_start_len", n, 16);
    chk("tmo_err", err, 1);
    chk("tmo_count", count, 0);
    chk("tmo_idle", idle, 1);

    // Abort during RUN with two tasks still queued
    do_reset();
    mode = 3;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      tp = 32'h500 + i;
      sp = 32'h600 + i;
      sb.push_back({32'h500 + i, 32'h600 + i});
      cyc(1);
    end
    push = 1'b0;
    n = 0;
    while (!busy && n < 30) begin
      cyc(1);
      n++;
    end
    chk("abt_busy_rise", busy, 1);
    cyc(1);
    abort = 1'b1;
    sb.delete();
    cyc(1);
    abort = 1'b0;
    chk("abt_level", level, 0);
    chk("abt_stop", stop, 1);
    n = 0;
    n2 = 0;
    repeat (20) begin
      if (stop) n++;
      if (start) n2++;
      cyc(1);
    end
    chk("abt_stop_len", n, 4);
    chk("abt_no_start", n2, 0);
    chk("abt_count", count, 0);
    chk("abt_idle", idle, 1);
    chk("abt_err", err, 0);

    // Reset in the middle of a task
    do_reset();
    mode = 2;
    for (int i = 0; i < 2; i++) begin
      push = 1'b1;
      tp = 32'h700 + i;
      sp = 32'h800 + i;
      sb.push_back({32'h700 + i, 32'h800 + i});
      cyc(1);
    end
    push = 1'b0;
    n = 0;
    while (!busy && n < 30) begin
      cyc(1);
      n++;
    end
    chk("mid_busy_rise", busy, 1);
    cyc(1);
    chk("mid_level", level, 1);
    reset = 1'b1;
    mode = 0;
    sb.delete();
    cyc(1);
    reset = 1'b0;
    chk("mid_start", start, 0);
    chk("mid_stop", stop, 0);
    chk("mid_level0", level, 0);
    chk("mid_idle", idle, 1);
    chk("mid_err", err, 0);
    chk("mid_ptr", task_ptr, 0);
    chk("mid_ready", ready, 1);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
